// File: rtl/time_set_ctrl.sv
// Time display sequencer: shows RTC time with blinking colons, edits HH:MM:SS with keys,
// and hands the edited time to the RTC writer over a req/ack handshake.
module time_set_ctrl #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BLINK_HZ  = 2,
  parameter int TIMEOUT_S = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_up,
  input  logic        key_down,
  input  logic [23:0] rtc_bcd,
  input  logic        rtc_valid,
  input  logic        wr_ack,
  output logic [23:0] disp_bcd,
  output logic [7:0]  en_0,
  output logic [7:0]  en_1,
  output logic [7:0]  en_2,
  output logic [7:0]  en_3,
  output logic [7:0]  en_4,
  output logic [7:0]  en_5,
  output logic [7:0]  dp_0,
  output logic [7:0]  dp_1,
  output logic        wr_req,
  output logic [23:0] wr_data,
  output logic [2:0]  state_dbg
);

  localparam int HALF      = CLK_FREQ / (2 * BLINK_HZ);
  localparam int TO_HALVES = 2 * BLINK_HZ * TIMEOUT_S;
  localparam int CW        = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int TW        = (TO_HALVES > 1) ? $clog2(TO_HALVES) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_HALVES - 1);

  // state_dbg encoding: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC, 4 WRITE
  localparam logic [2:0] S_RUN   = 3'd0;
  localparam logic [2:0] S_HOUR  = 3'd1;
  localparam logic [2:0] S_MIN   = 3'd2;
  localparam logic [2:0] S_SEC   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00) return max;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  logic [2:0]    state_q, state_d;
  logic [23:0]   edit_q, edit_d;
  logic [23:0]   disp_q, disp_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          wr_req_q, wr_req_d;
  logic [23:0]   wr_data_q, wr_data_d;
  logic [7:0]    en_q [6];
  logic [7:0]    en_d [6];
  logic [7:0]    dp_q, dp_d;

  logic       in_set, step, key_acc, half_tick, timeout;
  logic [5:0] blank_sel;

  always_comb begin
    state_d   = state_q;
    edit_d    = edit_q;
    disp_d    = disp_q;
    wr_req_d  = wr_req_q;
    wr_data_d = wr_data_q;
    in_set    = (state_q == S_HOUR) || (state_q == S_MIN) || (state_q == S_SEC);
    step      = key_up ^ key_down;
    key_acc   = (key_mode && (state_q == S_RUN || in_set)) || (in_set && step);
    half_tick = !key_acc && (blink_cnt_q == HALF_LAST);

    if (key_acc) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (half_tick) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + CW'(1);
      phase_d     = phase_q;
    end

    // Idle timeout counts blink half-periods since the last key while editing.
    to_cnt_d = '0;
    timeout  = 1'b0;
    if (in_set && !key_acc) begin
      to_cnt_d = to_cnt_q;
      if (half_tick) begin
        if (to_cnt_q == TO_LAST) timeout = 1'b1;
        else                     to_cnt_d = to_cnt_q + TW'(1);
      end
    end

    case (state_q)
      S_RUN: begin
        if (key_mode) begin
          state_d = S_HOUR;
          edit_d  = disp_q;
        end else if (rtc_valid) begin
          disp_d = rtc_bcd;
        end
      end
      S_HOUR, S_MIN, S_SEC: begin
        if (key_mode) begin
          if (state_q == S_SEC) begin
            state_d   = S_WRITE;
            wr_req_d  = 1'b1;
            wr_data_d = edit_q;
          end else begin
            state_d = state_q + 3'd1;
          end
        end else if (step) begin
          case (state_q)
            S_HOUR:  edit_d[23:16] = key_up ? bcd_inc(edit_q[23:16], 8'h23)
                                            : bcd_dec(edit_q[23:16], 8'h23);
            S_MIN:   edit_d[15:8]  = key_up ? bcd_inc(edit_q[15:8], 8'h59)
                                            : bcd_dec(edit_q[15:8], 8'h59);
            default: edit_d[7:0]   = key_up ? bcd_inc(edit_q[7:0], 8'h59)
                                            : bcd_dec(edit_q[7:0], 8'h59);
          endcase
        end else if (timeout) begin
          state_d = S_RUN;
          if (rtc_valid) disp_d = rtc_bcd;
        end
      end
      S_WRITE: begin
        // wr_req rises on entry and holds with wr_data stable until the single-cycle
        // wr_ack; the transfer completes on the cycle where both are high.
        if (wr_ack) begin
          wr_req_d = 1'b0;
          disp_d   = wr_data_q;
          state_d  = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase

    if (state_d == S_HOUR || state_d == S_MIN || state_d == S_SEC) disp_d = edit_d;

    case (state_d)
      S_HOUR:  blank_sel = 6'b000011;
      S_MIN:   blank_sel = 6'b001100;
      S_SEC:   blank_sel = 6'b110000;
      default: blank_sel = 6'b000000;
    endcase
    for (int i = 0; i < 6; i++) begin
      en_d[i] = (blank_sel[i] && !phase_d) ? 8'hFF : 8'h00;
    end
    dp_d = (state_d == S_RUN && !phase_d) ? 8'hFF : 8'h7F;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      edit_q      <= '0;
      disp_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      to_cnt_q    <= '0;
      wr_req_q    <= 1'b0;
      wr_data_q   <= '0;
      dp_q        <= 8'hFF;
      for (int i = 0; i < 6; i++) en_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      edit_q      <= edit_d;
      disp_q      <= disp_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      to_cnt_q    <= to_cnt_d;
      wr_req_q    <= wr_req_d;
      wr_data_q   <= wr_data_d;
      dp_q        <= dp_d;
      for (int i = 0; i < 6; i++) en_q[i] <= en_d[i];
    end
  end

  assign disp_bcd  = disp_q;
  assign en_0      = en_q[0];
  assign en_1      = en_q[1];
  assign en_2      = en_q[2];
  assign en_3      = en_q[3];
  assign en_4      = en_q[4];
  assign en_5      = en_q[5];
  assign dp_0      = dp_q;
  assign dp_1      = dp_q;
  assign wr_req    = wr_req_q;
  assign wr_data   = wr_data_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus randomized keys/RTC traffic, all
// checked against a cycle-level model that tracks the time as plain integers.
module tb_time_set_ctrl;

  localparam int HALF   = 10;
  localparam int TO_CYC = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_mode, key_up, key_down;
  logic [23:0] rtc_bcd;
  logic        rtc_valid, wr_ack;
  logic [23:0] disp_bcd, wr_data;
  logic [7:0]  en_0, en_1, en_2, en_3, en_4, en_5, dp_0, dp_1;
  logic        wr_req;
  logic [2:0]  state_dbg;
  logic [7:0]  en_w [6];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 RUN, 1..3 editing hour/min/sec, 4 WRITE; time kept as integers.
  int          m_st, m_h, m_m, m_s, m_elapsed;
  logic [23:0] m_disp, m_wr_data;
  logic        m_wr_req, m_fresh;
  logic [23:0] exp_q [$];

  always #5 clk = ~clk;

  time_set_ctrl #(.CLK_FREQ(40), .BLINK_HZ(2), .TIMEOUT_S(1)) dut (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
    .rtc_bcd(rtc_bcd), .rtc_valid(rtc_valid), .wr_ack(wr_ack), .disp_bcd(disp_bcd),
    .en_0(en_0), .en_1(en_1), .en_2(en_2), .en_3(en_3), .en_4(en_4), .en_5(en_5),
    .dp_0(dp_0), .dp_1(dp_1), .wr_req(wr_req), .wr_data(wr_data), .state_dbg(state_dbg)
  );

  assign en_w[0] = en_0;
  assign en_w[1] = en_1;
  assign en_w[2] = en_2;
  assign en_w[3] = en_3;
  assign en_w[4] = en_4;
  assign en_w[5] = en_5;

  function automatic logic [23:0] pack(int h, int m, int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] rand_time();
    return pack($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
  endfunction

  function automatic bit visible();
    return ((m_elapsed / HALF) % 2) == 0;
  endfunction

  function automatic logic [7:0] exp_en(int d);
    if (m_st >= 1 && m_st <= 3 && (d / 2) == m_st - 1) return visible() ? 8'h00 : 8'hFF;
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_dp();
    if (m_fresh) return 8'hFF;
    if (m_st == 0) return visible() ? 8'h7F : 8'hFF;
    return 8'h7F;
  endfunction

  task automatic model_reset();
    m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_elapsed = 0;
    m_disp = '0; m_wr_data = '0; m_wr_req = 1'b0; m_fresh = 1'b1;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit acc = 1'b0;
    int d;
    m_fresh = 1'b0;
    case (m_st)
      0: begin
        if (key_mode) begin
          acc = 1'b1;
          m_st = 1;
          m_h = int'(m_disp[23:20]) * 10 + int'(m_disp[19:16]);
          m_m = int'(m_disp[15:12]) * 10 + int'(m_disp[11:8]);
          m_s = int'(m_disp[7:4]) * 10 + int'(m_disp[3:0]);
        end else if (rtc_valid) begin
          m_disp = rtc_bcd;
        end
      end
      1, 2, 3: begin
        if (key_mode) begin
          acc = 1'b1;
          if (m_st == 3) begin
            m_st = 4;
            m_wr_req = 1'b1;
            m_wr_data = pack(m_h, m_m, m_s);
            exp_q.push_back(m_wr_data);
          end else begin
            m_st = m_st + 1;
          end
        end else if (key_up != key_down) begin
          acc = 1'b1;
          d = key_up ? 1 : -1;
          if (m_st == 1)      m_h = (m_h + 24 + d) % 24;
          else if (m_st == 2) m_m = (m_m + 60 + d) % 60;
          else                m_s = (m_s + 60 + d) % 60;
        end
      end
      default: begin
        if (wr_ack) begin
          m_wr_req = 1'b0;
          m_disp = m_wr_data;
          m_st = 0;
        end
      end
    endcase
    if (acc) m_elapsed = 0;
    else     m_elapsed = m_elapsed + 1;
    if (m_st >= 1 && m_st <= 3) begin
      if (!acc && m_elapsed == TO_CYC) begin
        m_st = 0;
        if (rtc_valid) m_disp = rtc_bcd;
      end else begin
        m_disp = pack(m_h, m_m, m_s);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    key_mode = 1'b0; key_up = 1'b0; key_down = 1'b0; wr_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_mode = 0; key_up = 0; key_down = 0; wr_ack = 0;
    rtc_valid = 0; rtc_bcd = '0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (disp_bcd !== 24'h0) begin n_fail++; $display("FAIL reset_disp: got %h want 000000", disp_bcd); end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (en_w[i] !== 8'h00) begin n_fail++; $display("FAIL reset_en%0d: got %h want 00", i, en_w[i]); end
    end
    n_checks++; if (dp_0 !== 8'hFF || dp_1 !== 8'hFF) begin n_fail++; $display("FAIL reset_dp: got %h/%h want FF/FF", dp_0, dp_1); end
    n_checks++; if (wr_req !== 1'b0 || wr_data !== 24'h0) begin n_fail++; $display("FAIL reset_wr: got %b/%h want 0/000000", wr_req, wr_data); end
    n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    rst = 1'b0;
  endtask

  task automatic test_run_display();
    rtc_bcd = 24'h235959; rtc_valid = 1'b1;
    tick();
    n_checks++; if (disp_bcd !== 24'h235959) begin n_fail++; $display("FAIL run_load: got %h want 235959", disp_bcd); end
    for (int c = 0; c < 30; c++) begin
      tick();
      n_checks++; if (dp_0 !== exp_dp() || dp_1 !== exp_dp()) begin n_fail++; $display("FAIL run_blink c%0d: got %h/%h want %h", c, dp_0, dp_1, exp_dp()); end
      n_checks++; if ({en_0, en_1, en_2, en_3, en_4, en_5} !== 48'h0) begin n_fail++; $display("FAIL run_en c%0d: got %h want 0", c, {en_0, en_1, en_2, en_3, en_4, en_5}); end
    end
  endtask

  task automatic test_set_hour();
    key_mode = 1'b1; tick();
    n_checks++; if (state_dbg !== 3'd1 || disp_bcd !== 24'h235959) begin n_fail++; $display("FAIL hour_enter: got %0d/%h want 1/235959", state_dbg, disp_bcd); end
    key_up = 1'b1; tick();
    n_checks++; if (disp_bcd !== 24'h005959) begin n_fail++; $display("FAIL hour_wrap_up: got %h want 005959", disp_bcd); end
    key_down = 1'b1; tick();
    n_checks++; if (disp_bcd !== 24'h235959) begin n_fail++; $display("FAIL hour_wrap_down: got %h want 235959", disp_bcd); end
    for (int c = 0; c < 25; c++) begin
      tick();
      for (int i = 0; i < 6; i++) begin
        n_checks++; if (en_w[i] !== exp_en(i)) begin n_fail++; $display("FAIL hour_blink c%0d en%0d: got %h want %h", c, i, en_w[i], exp_en(i)); end
      end
      n_checks++; if (dp_0 !== 8'h7F) begin n_fail++; $display("FAIL hour_dp c%0d: got %h want 7F", c, dp_0); end
    end
  endtask

  task automatic test_set_min_sec();
    key_mode = 1'b1; tick();
    key_up = 1'b1; tick();
    n_checks++; if (disp_bcd !== 24'h230059) begin n_fail++; $display("FAIL min_wrap_up: got %h want 230059", disp_bcd); end
    key_down = 1'b1; tick();
    n_checks++; if (disp_bcd !== 24'h235959) begin n_fail++; $display("FAIL min_wrap_down: got %h want 235959", disp_bcd); end
    key_mode = 1'b1; tick();
    for (int k = 0; k < 10; k++) begin key_up = 1'b1; tick(); end
    n_checks++; if (disp_bcd !== 24'h235909) begin n_fail++; $display("FAIL sec_to_09: got %h want 235909", disp_bcd); end
    key_up = 1'b1; tick();
    n_checks++; if (disp_bcd !== 24'h235910) begin n_fail++; $display("FAIL sec_carry: got %h want 235910", disp_bcd); end
    key_up = 1'b1; key_down = 1'b1; tick();
    n_checks++; if (disp_bcd !== 24'h235910) begin n_fail++; $display("FAIL up_down_both: got %h want 235910", disp_bcd); end
    n_checks++; if (en_4 !== exp_en(4) || en_0 !== 8'h00) begin n_fail++; $display("FAIL sec_en: got %h/%h want %h/00", en_4, en_0, exp_en(4)); end
  endtask

  task automatic test_write_hold();
    logic [23:0] want;
    key_mode = 1'b1; key_up = 1'b1; tick();
    n_checks++; if (wr_req !== 1'b1 || wr_data !== 24'h235910 || state_dbg !== 3'd4) begin
      n_fail++; $display("FAIL write_enter: got %b/%h/%0d want 1/235910/4", wr_req, wr_data, state_dbg); end
    for (int c = 0; c < 50; c++) begin
      key_mode = 1'($urandom_range(0, 1)); key_up = 1'($urandom_range(0, 1)); key_down = 1'($urandom_range(0, 1));
      tick();
      n_checks++; if (wr_req !== 1'b1 || wr_data !== 24'h235910 || state_dbg !== 3'd4) begin
        n_fail++; $display("FAIL write_hold c%0d: got %b/%h/%0d want 1/235910/4", c, wr_req, wr_data, state_dbg); end
    end
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hFFFFFF;
    n_checks++; if (wr_data !== want) begin n_fail++; $display("FAIL write_scoreboard: got %h want %h", wr_data, want); end
    wr_ack = 1'b1; tick();
    n_checks++; if (wr_req !== 1'b0 || state_dbg !== 3'd0 || disp_bcd !== 24'h235910) begin
      n_fail++; $display("FAIL write_ack: got %b/%0d/%h want 0/0/235910", wr_req, state_dbg, disp_bcd); end
  endtask

  task automatic test_timeout();
    int left = -1;
    bit saw_req = 1'b0;
    rtc_bcd = 24'h120000; rtc_valid = 1'b1;
    key_mode = 1'b1; tick();
    key_mode = 1'b1; tick();
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (wr_req) saw_req = 1'b1;
      if (left < 0 && state_dbg == 3'd0) left = i;
    end
    n_checks++; if (left !== TO_CYC) begin n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", left, TO_CYC); end
    n_checks++; if (saw_req !== 1'b0) begin n_fail++; $display("FAIL timeout_no_write: got %b want 0", saw_req); end
    rtc_bcd = 24'h134502; tick();
    n_checks++; if (disp_bcd !== 24'h134502 || disp_bcd !== m_disp) begin n_fail++; $display("FAIL timeout_follow: got %h want 134502", disp_bcd); end
  endtask

  task automatic test_reset_in_write();
    for (int k = 0; k < 4; k++) begin key_mode = 1'b1; tick(); end
    n_checks++; if (wr_req !== 1'b1 || wr_data !== 24'h134502) begin n_fail++; $display("FAIL rst_write_enter: got %b/%h want 1/134502", wr_req, wr_data); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (wr_req !== 1'b0 || state_dbg !== 3'd0 || disp_bcd !== 24'h0) begin
      n_fail++; $display("FAIL rst_async: got %b/%0d/%h want 0/0/000000", wr_req, state_dbg, disp_bcd); end
    model_reset();
    rtc_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (disp_bcd !== 24'h0 || wr_req !== 1'b0 || wr_data !== 24'h0 || state_dbg !== 3'd0) begin
        n_fail++; $display("FAIL rst_hold c%0d: got %h/%b/%h/%0d", c, disp_bcd, wr_req, wr_data, state_dbg); end
      n_checks++; if (dp_0 !== exp_dp()) begin n_fail++; $display("FAIL rst_dp c%0d: got %h want %h", c, dp_0, exp_dp()); end
    end
  endtask

  task automatic test_random();
    logic [23:0] want;
    for (int seg = 0; seg < 12; seg++) begin
      int dens = $urandom_range(2, 50);
      for (int c = 0; c < 150; c++) begin
        key_mode  = ($urandom_range(0, dens * 3) == 0);
        key_up    = ($urandom_range(0, dens) == 0);
        key_down  = ($urandom_range(0, dens) == 0);
        rtc_valid = 1'($urandom_range(0, 1));
        rtc_bcd   = rand_time();
        wr_ack    = ($urandom_range(0, 7) == 0);
        if (wr_req && wr_ack) begin
          want = (exp_q.size() != 0) ? exp_q.pop_front() : ~wr_data;
          n_checks++; if (wr_data !== want) begin n_fail++; $display("FAIL rand_commit s%0d c%0d: got %h want %h", seg, c, wr_data, want); end
        end
        tick();
        n_checks++; if (disp_bcd !== m_disp) begin n_fail++; $display("FAIL rand_disp s%0d c%0d: got %h want %h", seg, c, disp_bcd, m_disp); end
        for (int i = 0; i < 6; i++) begin
          n_checks++; if (en_w[i] !== exp_en(i)) begin n_fail++; $display("FAIL rand_en%0d s%0d c%0d: got %h want %h", i, seg, c, en_w[i], exp_en(i)); end
        end
        n_checks++; if (dp_0 !== exp_dp() || dp_1 !== exp_dp()) begin n_fail++; $display("FAIL rand_dp s%0d c%0d: got %h/%h want %h", seg, c, dp_0, dp_1, exp_dp()); end
        n_checks++; if (wr_req !== m_wr_req || wr_data !== m_wr_data) begin
          n_fail++; $display("FAIL rand_wr s%0d c%0d: got %b/%h want %b/%h", seg, c, wr_req, wr_data, m_wr_req, m_wr_data); end
        n_checks++; if (state_dbg !== 3'(m_st)) begin n_fail++; $display("FAIL rand_state s%0d c%0d: got %0d want %0d", seg, c, state_dbg, m_st); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run_display();
    test_set_hour();
    test_set_min_sec();
    test_write_hold();
    test_timeout();
    test_reset_in_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
